// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes a LEGv8 ALU/load/store word into an operand bundle behind a 2-entry skid buffer.
// Optional ILLEGAL_CNT_EN adds a saturating illegal_count output; in_ready depends only on registered state.
module alu_issue_stage #(
    parameter int DATA_W = 64
`ifdef ILLEGAL_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rn_data,
    input  logic [DATA_W-1:0] in_rm_data,
    input  logic [DATA_W-1:0] in_rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_A,
    output logic [DATA_W-1:0] out_B,
    output logic [2:0]        out_ALUOp,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [DATA_W-1:0] out_st_data,
    output logic              illegal
`ifdef ILLEGAL_CNT_EN
    , output logic [CNT_W-1:0] illegal_count
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic [4:0]        rd;
        logic              rw;
        logic              mr;
        logic              mw;
        logic [DATA_W-1:0] st;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, dec;
    logic   dec_legal;
    logic   acc_ok, out_xfer, take_illegal;
    logic   load_main, load_skid, move_skid;

    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        dec.a     = in_rn_data;
        dec.rd    = in_instr[4:0];
        case (in_instr[31:21])
            11'b10001011000: begin dec.op = 3'b000; dec.b = in_rm_data; dec.rw = 1'b1; end
            11'b11001011000: begin dec.op = 3'b001; dec.b = in_rm_data; dec.rw = 1'b1; end
            11'b10001010000: begin dec.op = 3'b010; dec.b = in_rm_data; dec.rw = 1'b1; end
            11'b10101010000: begin dec.op = 3'b011; dec.b = in_rm_data; dec.rw = 1'b1; end
            11'b11010011011: begin dec.op = 3'b101; dec.b = DATA_W'(in_instr[15:10]); dec.rw = 1'b1; end
            11'b11010011010: begin dec.op = 3'b100; dec.b = DATA_W'(in_instr[15:10]); dec.rw = 1'b1; end
            11'b11111000010: begin
                dec.b  = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
                dec.rw = 1'b1;
                dec.mr = 1'b1;
            end
            11'b11111000000: begin
                dec.b  = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
                dec.mw = 1'b1;
                dec.st = in_rt_data;
            end
            default: begin
                // Immediate forms only decode ten opcode bits; bit 21 belongs to imm12.
                if (in_instr[31:22] == 10'b1001000100) begin
                    dec.b  = DATA_W'(in_instr[21:10]);
                    dec.rw = 1'b1;
                end else if (in_instr[31:22] == 10'b1101000100) begin
                    dec.op = 3'b001;
                    dec.b  = DATA_W'(in_instr[21:10]);
                    dec.rw = 1'b1;
                end else begin
                    dec_legal = 1'b0;
                end
            end
        endcase
    end

    assign in_ready     = (state_q != TWO);
    assign out_valid    = (state_q != EMPTY);
    assign out_xfer     = out_valid && out_ready;
    assign acc_ok       = in_valid && in_ready && dec_legal && !flush;
    assign take_illegal = in_valid && in_ready && !dec_legal && !flush;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            EMPTY: if (acc_ok) begin state_d = ONE; load_main = 1'b1; end
            ONE: begin
                if (acc_ok && out_xfer) load_main = 1'b1;
                else if (acc_ok) begin state_d = TWO; load_skid = 1'b1; end
                else if (out_xfer) state_d = EMPTY;
            end
            TWO: if (out_xfer) begin state_d = ONE; move_skid = 1'b1; end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            move_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_main)      main_q <= dec;
            else if (move_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= dec;
            illegal <= take_illegal;
        end
    end

`ifdef ILLEGAL_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_count <= '0;
        else if (take_illegal && (illegal_count != {CNT_W{1'b1}}))
            illegal_count <= illegal_count + CNT_W'(1);
    end
`endif

    assign out_A         = main_q.a;
    assign out_B         = main_q.b;
    assign out_ALUOp     = main_q.op;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.rw;
    assign out_mem_read  = main_q.mr;
    assign out_mem_write = main_q.mw;
    assign out_st_data   = main_q.st;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors plus random traffic against a queue-based model.
module tb_alu_issue_stage;
    localparam int CNT_MAX = 65535;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [63:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] in_instr = '0;
    logic [63:0] in_rn_data = '0, in_rm_data = '0, in_rt_data = '0;
    logic [63:0] out_A, out_B, out_st_data;
    logic [2:0]  out_ALUOp;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;
`ifdef ILLEGAL_CNT_EN
    logic [15:0] illegal_count;
`endif

    always #5 clk = ~clk;

    alu_issue_stage #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rn_data(in_rn_data), .in_rm_data(in_rm_data), .in_rt_data(in_rt_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A(out_A), .out_B(out_B), .out_ALUOp(out_ALUOp), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_st_data(out_st_data),
        .illegal(illegal)
`ifdef ILLEGAL_CNT_EN
        , .illegal_count(illegal_count)
`endif
    );

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t got_q[$];
    bit   exp_ill = 0;
    int   exp_cnt = 0;
    bit   dut_acc;

    // Reference decode written straight from the instruction table, using integer arithmetic for extension.
    function automatic void ref_decode(input logic [31:0] ins, input logic [63:0] rn, rm, rt,
                                       output exp_t e, output bit ok);
        int unsigned op11 = ins[31:21];
        int unsigned op10 = ins[31:22];
        longint imm12 = longint'(ins[21:10]);
        longint shamt = longint'(ins[15:10]);
        longint d9    = longint'(ins[20:12]);
        if (d9 > 255) d9 = d9 - 512;
        e = '0; e.a = rn; e.rd = ins[4:0]; ok = 1;
        if      (op11 == 11'b10001011000) begin e.op = 0; e.b = rm; e.rw = 1; end
        else if (op11 == 11'b11001011000) begin e.op = 1; e.b = rm; e.rw = 1; end
        else if (op11 == 11'b10001010000) begin e.op = 2; e.b = rm; e.rw = 1; end
        else if (op11 == 11'b10101010000) begin e.op = 3; e.b = rm; e.rw = 1; end
        else if (op10 == 10'b1001000100)  begin e.op = 0; e.b = 64'(imm12); e.rw = 1; end
        else if (op10 == 10'b1101000100)  begin e.op = 1; e.b = 64'(imm12); e.rw = 1; end
        else if (op11 == 11'b11010011011) begin e.op = 5; e.b = 64'(shamt); e.rw = 1; end
        else if (op11 == 11'b11010011010) begin e.op = 4; e.b = 64'(shamt); e.rw = 1; end
        else if (op11 == 11'b11111000010) begin e.op = 0; e.b = 64'(d9); e.rw = 1; e.mr = 1; end
        else if (op11 == 11'b11111000000) begin e.op = 0; e.b = 64'(d9); e.mw = 1; e.st = rt; end
        else ok = 0;
    endfunction

    function automatic logic [31:0] gen_instr(input int k);
        logic [31:0] r = $urandom;
        case (k)
            0: r[31:21] = 11'b10001011000;
            1: r[31:21] = 11'b11001011000;
            2: r[31:21] = 11'b10001010000;
            3: r[31:21] = 11'b10101010000;
            4: r[31:22] = 10'b1001000100;
            5: r[31:22] = 10'b1101000100;
            6: r[31:21] = 11'b11010011011;
            7: r[31:21] = 11'b11010011010;
            8: r[31:21] = 11'b11111000010;
            9: r[31:21] = 11'b11111000000;
            10: r = 32'hFFFF_FFFF;
            default: ;
        endcase
        return r;
    endfunction

    function automatic exp_t dut_bundle();
        return {out_A, out_B, out_ALUOp, out_rd, out_reg_write, out_mem_read, out_mem_write, out_st_data};
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising edge, return at the next falling edge.
    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] rn, rm, rt,
                        input bit ordy, input bit fl);
        exp_t e;
        bit ok, acc, ox;
        in_valid = v; in_instr = ins; in_rn_data = rn; in_rm_data = rm; in_rt_data = rt;
        out_ready = ordy; flush = fl;
        ref_decode(ins, rn, rm, rt, e, ok);
        acc = v && (q.size() < 2);
        ox  = (q.size() > 0) && ordy;
        dut_acc = v && in_ready;
        if (out_valid && ordy) got_q.push_back(dut_bundle());
        @(posedge clk);
        exp_ill = 0;
        if (fl) q.delete();
        else begin
            if (ox) void'(q.pop_front());
            if (acc) begin
                if (ok) q.push_back(e);
                else begin
                    exp_ill = 1;
                    if (exp_cnt < CNT_MAX) exp_cnt++;
                end
            end
        end
        @(negedge clk);
        in_valid = 0; flush = 0;
    endtask

    task automatic idle(input bit ordy);
        step(0, 32'h0, 64'h0, 64'h0, 64'h0, ordy, 0);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%0b want=0", illegal); end
        checks++; if (dut_bundle() !== exp_t'(0)) begin failures++; $display("FAIL reset_outputs got=%h want=0", dut_bundle()); end
`ifdef ILLEGAL_CNT_EN
        checks++; if (illegal_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", illegal_count); end
`endif
        reset = 0;
        q.delete(); exp_ill = 0; exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_decode();
        exp_t w;
        step(1, 32'h8B020023, 64'd5, 64'd7, 64'd0, 1, 0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency got=%0b want=1", out_valid); end
        w = {64'd5, 64'd7, 3'b000, 5'd3, 1'b1, 1'b0, 1'b0, 64'd0};
        checks++; if (dut_bundle() !== w) begin failures++; $display("FAIL add_bundle got=%h want=%h", dut_bundle(), w); end
        step(1, 32'h91004025, 64'd1, 64'd99, 64'd0, 1, 0);
        w = {64'd1, 64'd16, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 64'd0};
        checks++; if (dut_bundle() !== w) begin failures++; $display("FAIL addi_bundle got=%h want=%h", dut_bundle(), w); end
        step(1, 32'hD3400C24, 64'h80, 64'd99, 64'd0, 1, 0);
        w = {64'h80, 64'd3, 3'b100, 5'd4, 1'b1, 1'b0, 1'b0, 64'd0};
        checks++; if (dut_bundle() !== w) begin failures++; $display("FAIL lsr_bundle got=%h want=%h", dut_bundle(), w); end
        step(1, 32'hF85F8022, 64'h100, 64'd99, 64'd0, 1, 0);
        w = {64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 3'b000, 5'd2, 1'b1, 1'b1, 1'b0, 64'd0};
        checks++; if (dut_bundle() !== w) begin failures++; $display("FAIL ldur_bundle got=%h want=%h", dut_bundle(), w); end
        step(1, 32'hF8008029, 64'h200, 64'd99, 64'hDEAD, 1, 0);
        w = {64'h200, 64'd8, 3'b000, 5'd9, 1'b0, 1'b0, 1'b1, 64'hDEAD};
        checks++; if (dut_bundle() !== w) begin failures++; $display("FAIL stur_bundle got=%h want=%h", dut_bundle(), w); end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_drain got=%0b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        exp_t w [3];
        bit ok;
        ins[0] = 32'h8B020023; ins[1] = 32'hCB050083; ins[2] = 32'hAA0300A6;
        for (int i = 0; i < 3; i++) ref_decode(ins[i], 64'(i + 10), 64'(i + 20), 64'd0, w[i], ok);
        got_q.delete();
        step(1, ins[0], 64'd10, 64'd20, 64'd0, 0, 0);
        step(1, ins[1], 64'd11, 64'd21, 64'd0, 0, 0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%0b want=0", in_ready); end
        step(1, ins[2], 64'd12, 64'd22, 64'd0, 0, 0);
        checks++; if (dut_bundle() !== w[0]) begin failures++; $display("FAIL b2b_stable got=%h want=%h", dut_bundle(), w[0]); end
        for (int c = 0; c < 10; c++) begin
            step(1, ins[2], 64'd12, 64'd22, 64'd0, 1, 0);
            if (dut_acc) break;
        end
        for (int c = 0; c < 10 && out_valid; c++) idle(1);
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== w[i]) begin failures++; $display("FAIL b2b_order%0d got=%h want=%h", i, got_q[i], w[i]); end
        end
    endtask

    task automatic test_illegal();
        for (int n = 1; n <= 2; n++) begin
            step(1, 32'hFFFF_FFFF, 64'd1, 64'd2, 64'd3, 1, 0);
            checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL ill_pulse%0d got=%0b want=1", n, illegal); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL ill_noentry%0d got=%0b%0b want=01", n, out_valid, in_ready); end
`ifdef ILLEGAL_CNT_EN
            checks++; if (illegal_count !== 16'(n)) begin failures++; $display("FAIL ill_count%0d got=%0d want=%0d", n, illegal_count, n); end
`endif
            idle(1);
            checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL ill_onecycle%0d got=%0b want=0", n, illegal); end
        end
    endtask

    task automatic test_flush();
        step(1, 32'h8B020023, 64'd1, 64'd2, 64'd0, 0, 0);
        step(1, 32'hCB020023, 64'd1, 64'd2, 64'd0, 0, 0);
        step(1, 32'h8A020023, 64'd1, 64'd2, 64'd0, 0, 1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_state got=%0b%0b want=01", out_valid, in_ready); end
        step(1, 32'hFFFF_FFFF, 64'd1, 64'd2, 64'd0, 1, 1);
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL flush_noillegal got=%0b want=0", illegal); end
        for (int c = 0; c < 3; c++) begin
            idle(1);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard%0d got=%0b want=0", c, out_valid); end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 32'h8B020023, 64'd1, 64'd2, 64'd0, 0, 0);
        step(1, 32'hCB020023, 64'd1, 64'd2, 64'd0, 0, 0);
        reset = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset got=%0b%0b want=01", out_valid, in_ready); end
        q.delete(); exp_ill = 0; exp_cnt = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
`ifdef ILLEGAL_CNT_EN
        checks++; if (illegal_count !== 16'd0) begin failures++; $display("FAIL midreset_count got=%0d want=0", illegal_count); end
`endif
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(3, 0) != 0, gen_instr($urandom_range(11, 0)),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(2, 0) != 0, $urandom_range(39, 0) == 0);
            checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, in_ready, q.size() < 2); end
            checks++; if (illegal !== exp_ill) begin failures++; $display("FAIL rnd_illegal c=%0d got=%0b want=%0b", c, illegal, exp_ill); end
            if (q.size() > 0) begin
                checks++; if (dut_bundle() !== q[0]) begin failures++; $display("FAIL rnd_bundle c=%0d got=%h want=%h", c, dut_bundle(), q[0]); end
            end
`ifdef ILLEGAL_CNT_EN
            checks++; if (illegal_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, illegal_count, exp_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID→EX issue stage of the ARMv8 pipeline: decodes a 32-bit LEGv8 instruction plus its register-read data.
- Produces the ALU operand/opcode bundle (A, B, ALUOp) and the control bits travelling with it.
- Two-entry skid buffer with valid/ready on both sides, so in_ready is registered and the EX stage can stall without a combinational ready path.

Parameters:
DATA_W, 64, operand width.
CNT_W, 16, illegal-instruction counter width (optional feature only).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  ID offers instruction
in_ready  out  1  stage can accept (registered)
in_instr  in  32  instruction word
in_rn_data  in  DATA_W  value of X[Rn]
in_rm_data  in  DATA_W  value of X[Rm]
in_rt_data  in  DATA_W  value of X[Rt] (store data)
out_valid  out  1  bundle valid
out_ready  in  1  EX accepts
out_A  out  DATA_W  ALU operand A
out_B  out  DATA_W  ALU operand B
out_ALUOp  out  3  000 add, 001 sub, 010 and, 011 orr, 100 lsr, 101 lsl
out_rd  out  5  destination/Rt index
out_reg_write  out  1  write-back enable
out_mem_read  out  1  load
out_mem_write  out  1  store
out_st_data  out  DATA_W  store data
illegal  out  1  one-cycle pulse: unsupported opcode consumed

Behaviour:
- Fields: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16], shamt=[15:10], imm12=[21:10], dt9=[20:12].
- Decode table (opcode → ALUOp, B, ctrl):
  - ADD 10001011000 → 000, B=Rm, rw.
  - SUB 11001011000 → 001, B=Rm, rw.
  - AND 10001010000 → 010, B=Rm, rw.
  - ORR 10101010000 → 011, B=Rm, rw.
  - ADDI [31:22]=1001000100 → 000, B=zext(imm12), rw.
  - SUBI 1101000100 → 001, B=zext(imm12), rw.
  - LSL 11010011011 → 101, B=zext(shamt), rw.
  - LSR 11010011010 → 100, B=zext(shamt), rw.
  - LDUR 11111000010 → 000, B=sext(dt9), rw, mem_read.
  - STUR 11111000000 → 000, B=sext(dt9), mem_write, st_data=in_rt_data.
- A = in_rn_data in all cases. Anything else is illegal.
- Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. out_* stay stable while out_valid&&!out_ready.
- Illegal instruction: handshake completes, no entry is created, illegal pulses the next cycle.
- FSM on buffer occupancy:
  - EMPTY: out_valid=0, in_ready=1. Legal accept → ONE.
  - ONE: main entry drives out_*, in_ready=1.
    - legal accept without output transfer → TWO (entry stored in skid).
    - output transfer without accept → EMPTY.
    - both → stay ONE, main reloaded from input.
  - TWO: in_ready=0.
    - output transfer → skid moves to main → ONE.
- Latency: one cycle from accept to out_valid when EMPTY. Sustained throughput one per cycle.
- Flush: next state EMPTY, out_valid=0, in_ready=1. An input accepted in the flush cycle is discarded, and no illegal pulse is generated for it.
- Reset: state EMPTY; out_valid=0, in_ready=1, illegal=0, all data/control outputs 0. Asserting reset mid-operation drops all entries immediately.
- No arithmetic is performed here; sign/zero extension to DATA_W only.

Optional Feature:
ILLEGAL_CNT_EN
- Defined: adds output illegal_count[CNT_W-1:0].
  - Increments by 1 on each consumed illegal instruction and saturates at all-ones.
  - Reset to 0; flush does not clear it.
- Undefined: port and counter absent. illegal pulse behaviour is unchanged.

Test Plan:
- Reset released, in_instr=0x8B020023 (ADD X3,X1,X2), rn=5, rm=7, out_ready=1 → next cycle out_valid=1, A=5, B=7, ALUOp=000, rd=3, reg_write=1.
- 0x91004025 (ADDI X5,X1,#16) → B=16, ALUOp=000, rd=5. Then 0xD3400C24 (LSR X4,X1,#3) → B=3, ALUOp=100.
- 0xF85F8022 (LDUR X2,[X1,#-8]), rn=0x100 → B=0xFFFF_FFFF_FFFF_FFF8, mem_read=1, reg_write=1, rd=2.
- out_ready=0 with three back-to-back legal instructions → two accepted, in_ready=0 on the third cycle. Release out_ready → outputs in original order, none lost or duplicated.
- in_instr=0xFFFFFFFF → in_ready stays 1, out_valid stays 0, illegal=1 for one cycle; with ILLEGAL_CNT_EN, illegal_count=1. A second illegal gives 2.
- Buffer in TWO, assert flush for one cycle → out_valid=0 and in_ready=1 next cycle; an instruction offered during flush never appears at the output.
